// File: rtl/hist_pp_pkg.sv
// Shared definitions for the histogram ping-pong bank controller.
//   NUM_BANKS    : number of banks in the external RAM (ping + pong)
//   bank_state_e : per-bank ownership state, EMPTY (producer may fill)
//                  or FULL (consumer may drain)
package hist_pp_pkg;

  localparam int NUM_BANKS = 2;

  typedef enum logic [0:0] {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_e;

endpackage

// File: rtl/hist_pp_bank_flag.sv
// Single bank EMPTY/FULL flag.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset, forces EMPTY
//   set   : mark bank FULL on next edge (producer finished it)
//   clr   : mark bank EMPTY on next edge (consumer finished it)
//   state : current bank state
module hist_pp_bank_flag
  import hist_pp_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set,
  input  logic        clr,
  output bank_state_e state
);

  // Bank state register; set and clr never coincide on one bank, set wins if they did.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BANK_EMPTY;
    end else if (set) begin
      state <= BANK_FULL;
    end else if (clr) begin
      state <= BANK_EMPTY;
    end else begin
      state <= state;
    end
  end

endmodule

// File: rtl/hist_pingpong_ctrl.sv
// Ping-pong bank controller between a histogram producer and a consumer
// sharing an external 2-bank RAM.
//   ap_clk, ap_rst_n : clock, async active-low reset
//   i_write          : producer finished its current bank
//   i_full_n         : producer bank is EMPTY (producer ap_continue)
//   t_read           : consumer finished its current bank
//   t_empty_n        : consumer bank is FULL (consumer ap_start)
//   i_address        : producer word address
//   t_address        : consumer word address
//   mem_i_address    : {i_bank, i_address} to RAM producer port
//   mem_t_address    : {t_bank, t_address} to RAM consumer port
//   i_bank, t_bank   : bank owned by producer / consumer
//   count            : number of FULL banks
//   err              : sticky protocol error (write-to-full / read-from-empty)
module hist_pingpong_ctrl
  import hist_pp_pkg::*;
#(
  parameter int AW = 8
) (
  input  logic          ap_clk,
  input  logic          ap_rst_n,
  input  logic          i_write,
  output logic          i_full_n,
  input  logic          t_read,
  output logic          t_empty_n,
  input  logic [AW-1:0] i_address,
  input  logic [AW-1:0] t_address,
  output logic [AW:0]   mem_i_address,
  output logic [AW:0]   mem_t_address,
  output logic          i_bank,
  output logic          t_bank,
  output logic [1:0]    count,
  output logic          err
);

  logic                 i_bank_r;
  logic                 t_bank_r;
  logic [1:0]           count_r;
  logic                 err_r;
  bank_state_e          bank_state_s [NUM_BANKS];
  logic [NUM_BANKS-1:0] set_s;
  logic [NUM_BANKS-1:0] clr_s;
  logic                 full_n_s;
  logic                 empty_n_s;
  logic                 wr_acc_s;
  logic                 rd_acc_s;
  logic                 wr_err_s;
  logic                 rd_err_s;

  // Handshake flags come from registers only, never from i_write / t_read.
  assign full_n_s  = (bank_state_s[i_bank_r] == BANK_EMPTY);
  assign empty_n_s = (bank_state_s[t_bank_r] == BANK_FULL);

  // Acceptance and protocol-error decode.
  always_comb begin
    wr_acc_s = i_write & full_n_s;
    rd_acc_s = t_read & empty_n_s;
    wr_err_s = i_write & ~full_n_s;
    rd_err_s = t_read & ~empty_n_s;
  end

  // Per-bank set/clear strobes steered by the owning pointer.
  always_comb begin
    set_s = '0;
    clr_s = '0;
    if (wr_acc_s) begin
      set_s[i_bank_r] = 1'b1;
    end else begin
      set_s[i_bank_r] = 1'b0;
    end
    if (rd_acc_s) begin
      clr_s[t_bank_r] = 1'b1;
    end else begin
      clr_s[t_bank_r] = 1'b0;
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    hist_pp_bank_flag u_flag (
      .clk   (ap_clk),
      .rst_n (ap_rst_n),
      .set   (set_s[b]),
      .clr   (clr_s[b]),
      .state (bank_state_s[b])
    );
  end

  // Producer bank pointer: advance after each accepted write.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      i_bank_r <= 1'b0;
    end else if (wr_acc_s) begin
      i_bank_r <= ~i_bank_r;
    end else begin
      i_bank_r <= i_bank_r;
    end
  end

  // Consumer bank pointer: advance after each accepted read.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      t_bank_r <= 1'b0;
    end else if (rd_acc_s) begin
      t_bank_r <= ~t_bank_r;
    end else begin
      t_bank_r <= t_bank_r;
    end
  end

  // FULL-bank counter; acceptance gating keeps it within 0..2 without wrap.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      count_r <= 2'd0;
    end else begin
      case ({wr_acc_s, rd_acc_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  // Sticky protocol error, cleared only by reset.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      err_r <= 1'b0;
    end else begin
      err_r <= err_r | wr_err_s | rd_err_s;
    end
  end

  assign i_full_n      = full_n_s;
  assign t_empty_n     = empty_n_s;
  assign i_bank        = i_bank_r;
  assign t_bank        = t_bank_r;
  assign count         = count_r;
  assign err           = err_r;
  assign mem_i_address = {i_bank_r, i_address};
  assign mem_t_address = {t_bank_r, t_address};

endmodule

// File: tb/tb_hist_pingpong_ctrl.sv
// Self-checking bench for hist_pingpong_ctrl: directed scenarios plus random
// traffic, checked against an occupancy-based reference model.
module tb_hist_pingpong_ctrl;

  localparam int AW = 8;

  logic          ap_clk = 1'b0;
  logic          ap_rst_n;
  logic          i_write;
  logic          i_full_n;
  logic          t_read;
  logic          t_empty_n;
  logic [AW-1:0] i_address;
  logic [AW-1:0] t_address;
  logic [AW:0]   mem_i_address;
  logic [AW:0]   mem_t_address;
  logic          i_bank;
  logic          t_bank;
  logic [1:0]    count;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: number of full banks, total accepted writes/reads, error.
  int m_n;
  int m_w;
  int m_r;
  bit m_err;

  hist_pingpong_ctrl #(.AW(AW)) dut (
    .ap_clk        (ap_clk),
    .ap_rst_n      (ap_rst_n),
    .i_write       (i_write),
    .i_full_n      (i_full_n),
    .t_read        (t_read),
    .t_empty_n     (t_empty_n),
    .i_address     (i_address),
    .t_address     (t_address),
    .mem_i_address (mem_i_address),
    .mem_t_address (mem_t_address),
    .i_bank        (i_bank),
    .t_bank        (t_bank),
    .count         (count),
    .err           (err)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_n = 0; m_w = 0; m_r = 0; m_err = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "/count"},     32'(count),         32'(m_n));
    chk({tag, "/i_full_n"},  32'(i_full_n),      32'(m_n < 2));
    chk({tag, "/t_empty_n"}, 32'(t_empty_n),     32'(m_n > 0));
    chk({tag, "/i_bank"},    32'(i_bank),        32'(m_w % 2));
    chk({tag, "/t_bank"},    32'(t_bank),        32'(m_r % 2));
    chk({tag, "/err"},       32'(err),           32'(m_err));
    chk({tag, "/mem_i"},     32'(mem_i_address), 32'((m_w % 2) * (1 << AW) + int'(i_address)));
    chk({tag, "/mem_t"},     32'(mem_t_address), 32'((m_r % 2) * (1 << AW) + int'(t_address)));
  endtask

  // One clock cycle of stimulus, entered and left at a falling edge.
  task automatic cycle(input bit w, input bit r);
    bit acc_w;
    bit acc_r;
    i_write   = w;
    t_read    = r;
    i_address = AW'($urandom);
    t_address = AW'($urandom);
    #1;
    check_all("pre");
    acc_w = w && (m_n < 2);
    acc_r = r && (m_n > 0);
    @(posedge ap_clk);
    if (w && !acc_w) m_err = 1'b1;
    if (r && !acc_r) m_err = 1'b1;
    m_n = m_n + int'(acc_w) - int'(acc_r);
    m_w = m_w + int'(acc_w);
    m_r = m_r + int'(acc_r);
    @(negedge ap_clk);
    i_write = 1'b0;
    t_read  = 1'b0;
  endtask

  task automatic do_reset();
    ap_rst_n = 1'b0;
    model_reset();
    @(negedge ap_clk);
    check_all("rst");
    ap_rst_n = 1'b1;
  endtask

  initial begin
    i_write   = 1'b0;
    t_read    = 1'b0;
    i_address = '0;
    t_address = '0;
    model_reset();
    do_reset();
    chk("rst_full_n", 32'(i_full_n), 32'd1);
    chk("rst_empty_n", 32'(t_empty_n), 32'd0);

    // Single write after reset hands bank 0 to the consumer.
    cycle(1'b1, 1'b0);
    #1;
    chk("w1_count", 32'(count), 32'd1);
    chk("w1_i_bank", 32'(i_bank), 32'd1);
    chk("w1_t_empty_n", 32'(t_empty_n), 32'd1);
    chk("w1_i_full_n", 32'(i_full_n), 32'd1);
    chk("w1_mem_t", 32'(mem_t_address), 32'({1'b0, t_address}));

    // Simultaneous write and read with one bank full.
    cycle(1'b1, 1'b1);
    #1;
    chk("wr_count", 32'(count), 32'd1);
    chk("wr_i_bank", 32'(i_bank), 32'd0);
    chk("wr_t_bank", 32'(t_bank), 32'd1);
    chk("wr_err", 32'(err), 32'd0);

    // Fill both banks, then a write to full is ignored and flagged.
    do_reset();
    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b0);
    #1;
    chk("w2_count", 32'(count), 32'd2);
    chk("w2_full_n", 32'(i_full_n), 32'd0);
    cycle(1'b1, 1'b0);
    #1;
    chk("w3_err", 32'(err), 32'd1);
    chk("w3_count", 32'(count), 32'd2);

    // Asynchronous reset between edges with both banks full.
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_full_n", 32'(i_full_n), 32'd1);
    chk("arst_empty_n", 32'(t_empty_n), 32'd0);
    chk("arst_err", 32'(err), 32'd0);
    model_reset();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;

    // Read from empty after reset.
    cycle(1'b0, 1'b1);
    #1;
    chk("re_err", 32'(err), 32'd1);
    chk("re_t_bank", 32'(t_bank), 32'd0);
    chk("re_count", 32'(count), 32'd0);

    // Ten write/read rounds with random gaps.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cycle(1'b1, 1'b0);
      repeat ($urandom_range(0, 3)) cycle(1'b0, 1'b0);
      #1;
      chk("round_t_bank", 32'(t_bank), 32'(k % 2));
      chk("round_cnt_le2", 32'(count <= 2'd2), 32'd1);
      cycle(1'b0, 1'b1);
      repeat ($urandom_range(0, 3)) cycle(1'b0, 1'b0);
    end
    #1;
    chk("rounds_err", 32'(err), 32'd0);
    chk("rounds_t_bank", 32'(t_bank), 32'd0);

    // Random traffic, including protocol violations.
    do_reset();
    for (int k = 0; k < 300; k++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    #1;
    check_all("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hist_pingpong_ctrl.md
HIST_PINGPONG_CTRL -- requirements
Module: hist_pingpong_ctrl

Interface
REQ-001 Parameter: AW, default 8, per-bank word address width; each bank holds 2**AW words.
REQ-002 ap_clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 ap_rst_n  in  1  reset, asynchronous, active-low.
REQ-004 i_write  in  1  producer pulse: current producer bank is complete (producer ap_done).
REQ-005 i_full_n  out  1  high when the producer bank is EMPTY; drives producer ap_continue.
REQ-006 t_read  in  1  consumer pulse: current consumer bank is consumed (consumer ap_ready).
REQ-007 t_empty_n  out  1  high when the consumer bank is FULL; drives consumer ap_start.
REQ-008 i_address  in  AW  producer word address.
REQ-009 t_address  in  AW  consumer word address.
REQ-010 mem_i_address  out  AW+1  {i_bank, i_address}, producer port of the 2-bank RAM.
REQ-011 mem_t_address  out  AW+1  {t_bank, t_address}, consumer port of the 2-bank RAM.
REQ-012 i_bank  out  1  bank index currently owned by the producer.
REQ-013 t_bank  out  1  bank index currently owned by the consumer.
REQ-014 count  out  2  number of FULL banks, 0..2.
REQ-015 err  out  1  sticky protocol-error flag.

Function
REQ-016 Each bank holds a state: EMPTY or FULL; i_bank and t_bank are 1-bit pointers.
REQ-017 i_full_n = (state[i_bank] == EMPTY); t_empty_n = (state[t_bank] == FULL); both are combinational from registers only, with no combinational path from i_write or t_read.
REQ-018 Accepted write (i_write & i_full_n):
- state[i_bank] <= FULL
- i_bank toggles
- takes effect on the next edge.
REQ-019 Accepted read (t_read & t_empty_n):
- state[t_bank] <= EMPTY
- t_bank toggles
- takes effect on the next edge.
REQ-020 Accepted write and accepted read in the same cycle are both applied; count is unchanged.
- Both accepted with i_bank == t_bank is impossible: that bank cannot be both EMPTY and FULL.
REQ-021 count increments by 1 on an accepted write only, decrements by 1 on an accepted read only; it never wraps and always equals the number of FULL banks.
REQ-022 i_write while i_full_n = 0 (write to full) is ignored and sets err.
REQ-023 t_read while t_empty_n = 0 (read from empty) is ignored and sets err.
REQ-024 err clears only on reset.
REQ-025 Latency:
- bank handoff from producer to consumer: 1 cycle, i.e. t_empty_n rises the cycle after an accepted write into the bank at t_bank.
- with both banks EMPTY, the producer sees i_full_n = 1 the cycle after its write, on the other bank.
REQ-026 mem_i_address and mem_t_address are purely combinational, zero latency.

Reset
REQ-027 While ap_rst_n = 0, asynchronously:
- both banks EMPTY
- i_bank = 0, t_bank = 0
- count = 0, err = 0
- hence i_full_n = 1, t_empty_n = 0.
REQ-028 Reset asserted mid-operation discards all bank contents' validity immediately; the first edge after deassertion behaves as from power-up.

Structure
REQ-029 Shared package hist_pp_pkg holds:
- bank-state enum (BANK_EMPTY = 0, BANK_FULL = 1)
- constant NUM_BANKS = 2.
REQ-030 One sub-module, hist_pp_bank_flag: a single bank's EMPTY/FULL register with set/clear inputs and async active-low reset, instantiated twice.
REQ-031 No memory is inside this block; the 2-bank RAM is external.

Verification
REQ-032 Reset, then i_write pulse -> next cycle: count = 1, i_bank = 1, t_empty_n = 1, i_full_n = 1, mem_t_address = {0, t_address}.
REQ-033 Two i_write pulses, no t_read -> count = 2, i_full_n = 0; third i_write -> ignored, err = 1, count stays 2.
REQ-034 count = 1, then i_write and t_read in the same cycle -> count stays 1, i_bank and t_bank both toggle, err = 0.
REQ-035 t_read after reset -> ignored, err = 1, t_bank = 0, count = 0.
REQ-036 Run 10 write/read rounds with random gaps -> t_bank alternates 0,1,0,...; count never exceeds 2; err = 0.
REQ-037 Assert ap_rst_n = 0 with count = 2, asynchronously between edges -> immediately count = 0, i_full_n = 1, t_empty_n = 0.
